// File: rtl/id_pipe_if.sv
// rtl/id_pipe_if.sv - handshake, regfile, forwarding and ID/EX bundle for id_pipe
//
// Purpose: groups every id_pipe signal except clk/rst.
//   master : the decode stage (id_pipe) side
//   slave  : the surrounding pipeline (IF/ID, regfile, EX/MEM, EX stage)
// Signals:
//   in_valid/in_ready, pc_i, inst_i          IF/ID handshake and payload
//   reg{1,2}_read_o, reg{1,2}_addr_o          regfile read requests
//   reg{1,2}_data_i                           regfile read data (same cycle)
//   ex_*/mem_*                                in-flight results for forwarding/hazards
//   out_valid/out_ready, pc_o ... wreg_o      ID/EX register and handshake
//   inst_invalid_o, stall_cnt_o               status
interface id_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int CNT_W    = 16
) ();
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         pc_i;
  logic [31:0]         inst_i;
  logic                reg1_read_o;
  logic                reg2_read_o;
  logic [REG_AW-1:0]   reg1_addr_o;
  logic [REG_AW-1:0]   reg2_addr_o;
  logic [DATA_W-1:0]   reg1_data_i;
  logic [DATA_W-1:0]   reg2_data_i;
  logic                ex_wreg_i;
  logic [REG_AW-1:0]   ex_wd_i;
  logic [DATA_W-1:0]   ex_wdata_i;
  logic                ex_is_load_i;
  logic                mem_wreg_i;
  logic [REG_AW-1:0]   mem_wd_i;
  logic [DATA_W-1:0]   mem_wdata_i;
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         pc_o;
  logic [ALUOP_W-1:0]  aluop_o;
  logic [ALUSEL_W-1:0] alusel_o;
  logic [DATA_W-1:0]   reg1_o;
  logic [DATA_W-1:0]   reg2_o;
  logic [REG_AW-1:0]   wd_o;
  logic                wreg_o;
  logic                inst_invalid_o;
  logic [CNT_W-1:0]    stall_cnt_o;

  modport master (
    input  in_valid, pc_i, inst_i, reg1_data_i, reg2_data_i,
    input  ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
    input  mem_wreg_i, mem_wd_i, mem_wdata_i, out_ready,
    output in_ready, reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o,
    output out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o,
    output inst_invalid_o, stall_cnt_o
  );

  modport slave (
    output in_valid, pc_i, inst_i, reg1_data_i, reg2_data_i,
    output ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i,
    output mem_wreg_i, mem_wd_i, mem_wdata_i, out_ready,
    input  in_ready, reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o,
    input  out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o,
    input  inst_invalid_o, stall_cnt_o
  );
endinterface

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - registered MIPS32 instruction-decode stage with forwarding
//
// Purpose: decodes AND/OR/XOR/NOR, ANDI/ORI/XORI, LUI and LW, selects operands
// with EX/MEM forwarding, stalls on load-use hazards and drives a registered
// ID/EX stage under valid/ready flow control.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : id_pipe_if.master (handshakes, regfile reads, forwarding, ID/EX outputs)
module id_pipe #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rst,
  id_pipe_if.master     bus
);

  logic [5:0]          w_op;
  logic [5:0]          w_funct;
  logic [REG_AW-1:0]   w_rs;
  logic [REG_AW-1:0]   w_rt;
  logic [REG_AW-1:0]   w_rd;
  logic [ALUOP_W-1:0]  w_aluop;
  logic [ALUSEL_W-1:0] w_alusel;
  logic                w_re1;
  logic                w_re2;
  logic [REG_AW-1:0]   w_wd;
  logic                w_wreg;
  logic                w_inv;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_op1;
  logic [DATA_W-1:0]   w_op2;
  logic                w_hazard;
  logic                w_load;

  logic                r_valid;
  logic [31:0]         r_pc;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [ALUSEL_W-1:0] r_alusel;
  logic [DATA_W-1:0]   r_reg1;
  logic [DATA_W-1:0]   r_reg2;
  logic [REG_AW-1:0]   r_wd;
  logic                r_wreg;
  logic                r_inv;
  logic [CNT_W-1:0]    r_stall;

  assign w_op    = bus.inst_i[31:26];
  assign w_funct = bus.inst_i[5:0];
  assign w_rs    = REG_AW'(bus.inst_i[25:21]);
  assign w_rt    = REG_AW'(bus.inst_i[20:16]);
  assign w_rd    = REG_AW'(bus.inst_i[15:11]);

  always_comb begin
    w_aluop  = '0;
    w_alusel = '0;
    w_re1    = 1'b0;
    w_re2    = 1'b0;
    w_wd     = '0;
    w_wreg   = 1'b0;
    w_inv    = 1'b0;
    w_imm    = '0;
    case (w_op)
      6'b000000: begin
        // the all-zero word is the canonical NOP and is not flagged
        if (bus.inst_i != 32'h0) begin
          if (w_funct[5:2] == 4'b1001) begin
            w_aluop  = ALUOP_W'({2'b00, w_funct});
            w_alusel = ALUSEL_W'(3'b001);
            w_re1    = 1'b1;
            w_re2    = 1'b1;
            w_wd     = w_rd;
            w_wreg   = 1'b1;
          end else begin
            w_inv = 1'b1;
          end
        end
      end
      6'b001100, 6'b001101, 6'b001110: begin
        // opcode low bits line up with the AND/OR/XOR aluop low bits
        w_aluop  = ALUOP_W'({6'b001001, w_op[1:0]});
        w_alusel = ALUSEL_W'(3'b001);
        w_re1    = 1'b1;
        w_imm    = DATA_W'(bus.inst_i[15:0]);
        w_wd     = w_rt;
        w_wreg   = 1'b1;
      end
      6'b001111: begin
        w_aluop  = ALUOP_W'(8'h25);
        w_alusel = ALUSEL_W'(3'b001);
        w_re1    = 1'b1;
        w_imm    = DATA_W'({bus.inst_i[15:0], 16'h0000});
        w_wd     = w_rt;
        w_wreg   = 1'b1;
      end
      6'b100011: begin
        w_aluop  = ALUOP_W'(8'hE3);
        w_alusel = ALUSEL_W'(3'b111);
        w_re1    = 1'b1;
        w_imm    = DATA_W'($signed(bus.inst_i[15:0]));
        w_wd     = w_rt;
        w_wreg   = 1'b1;
      end
      default: w_inv = 1'b1;
    endcase
  end

  function automatic logic [DATA_W-1:0] f_operand(
    input logic re, input logic [REG_AW-1:0] addr,
    input logic [DATA_W-1:0] rf_data, input logic [DATA_W-1:0] imm,
    input logic ex_wreg, input logic [REG_AW-1:0] ex_wd, input logic [DATA_W-1:0] ex_wdata,
    input logic mem_wreg, input logic [REG_AW-1:0] mem_wd, input logic [DATA_W-1:0] mem_wdata);
    if (!re)                                         return imm;
    else if (addr == '0)                             return '0;
    else if (FWD_EN != 0 && ex_wreg && ex_wd == addr)   return ex_wdata;
    else if (FWD_EN != 0 && mem_wreg && mem_wd == addr) return mem_wdata;
    else                                             return rf_data;
  endfunction

  // A source hits when its producer cannot supply the value in time: a load
  // still in EX always, and any in-flight write when forwarding is off.
  function automatic logic f_hit(
    input logic re, input logic [REG_AW-1:0] addr,
    input logic ex_wreg, input logic [REG_AW-1:0] ex_wd, input logic ex_is_load,
    input logic mem_wreg, input logic [REG_AW-1:0] mem_wd);
    logic ex_m;
    logic mem_m;
    ex_m  = ex_wreg && (ex_wd == addr);
    mem_m = mem_wreg && (mem_wd == addr);
    return re && (addr != '0) &&
           ((ex_m && ex_is_load) || (FWD_EN == 0 && (ex_m || mem_m)));
  endfunction

  assign w_op1 = f_operand(w_re1, w_rs, bus.reg1_data_i, '0,
                           bus.ex_wreg_i, bus.ex_wd_i, bus.ex_wdata_i,
                           bus.mem_wreg_i, bus.mem_wd_i, bus.mem_wdata_i);
  assign w_op2 = f_operand(w_re2, w_rt, bus.reg2_data_i, w_imm,
                           bus.ex_wreg_i, bus.ex_wd_i, bus.ex_wdata_i,
                           bus.mem_wreg_i, bus.mem_wd_i, bus.mem_wdata_i);

  assign w_hazard = bus.in_valid &&
      (f_hit(w_re1, w_rs, bus.ex_wreg_i, bus.ex_wd_i, bus.ex_is_load_i, bus.mem_wreg_i, bus.mem_wd_i) ||
       f_hit(w_re2, w_rt, bus.ex_wreg_i, bus.ex_wd_i, bus.ex_is_load_i, bus.mem_wreg_i, bus.mem_wd_i));

  assign bus.in_ready = ~w_hazard & (~r_valid | bus.out_ready);
  assign w_load       = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_aluop  <= '0;
      r_alusel <= '0;
      r_reg1   <= '0;
      r_reg2   <= '0;
      r_wd     <= '0;
      r_wreg   <= 1'b0;
      r_inv    <= 1'b0;
      r_stall  <= '0;
    end else begin
      if (w_load) begin
        r_valid  <= 1'b1;
        r_pc     <= bus.pc_i;
        r_aluop  <= w_aluop;
        r_alusel <= w_alusel;
        r_reg1   <= w_op1;
        r_reg2   <= w_op2;
        r_wd     <= w_wd;
        r_wreg   <= w_wreg;
        r_inv    <= w_inv;
      end else if (bus.out_ready || !r_valid) begin
        // bubble; an instruction still held by EX back-pressure is never dropped
        r_valid <= 1'b0;
        r_wreg  <= 1'b0;
      end
      if (w_hazard && r_stall != '1) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

  assign bus.reg1_read_o    = w_re1;
  assign bus.reg2_read_o    = w_re2;
  assign bus.reg1_addr_o    = w_rs;
  assign bus.reg2_addr_o    = w_rt;
  assign bus.out_valid      = r_valid;
  assign bus.pc_o           = r_pc;
  assign bus.aluop_o        = r_aluop;
  assign bus.alusel_o       = r_alusel;
  assign bus.reg1_o         = r_reg1;
  assign bus.reg2_o         = r_reg2;
  assign bus.wd_o           = r_wd;
  assign bus.wreg_o         = r_wreg;
  assign bus.inst_invalid_o = r_inv;
  assign bus.stall_cnt_o    = r_stall;

endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - self-checking bench for id_pipe
module tb_id_pipe;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_pipe_if #(.DATA_W(32), .REG_AW(5), .ALUOP_W(8), .ALUSEL_W(3), .CNT_W(16)) bus ();

  id_pipe #(.DATA_W(32), .REG_AW(5), .ALUOP_W(8), .ALUSEL_W(3), .FWD_EN(1), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // behavioural register file answering the stage's read addresses
  logic [31:0] rf [32];
  always_comb begin
    bus.reg1_data_i = rf[bus.reg1_addr_o];
    bus.reg2_data_i = rf[bus.reg2_addr_o];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // instruction kinds: 0-3 AND/OR/XOR/NOR, 4-6 ANDI/ORI/XORI, 7 LUI, 8 LW,
  // 9 NOP, 10 unknown opcode, 11 SPECIAL with unsupported funct (ADD)
  int          c_kind;
  logic [4:0]  c_rs, c_rt, c_rd;
  logic [15:0] c_imm;

  // reference ID/EX register contents
  logic        m_valid;
  logic [31:0] m_pc, m_r1, m_r2;
  logic [7:0]  m_aluop;
  logic [2:0]  m_sel;
  logic [4:0]  m_wd;
  logic        m_wreg, m_inv;
  int          m_stall;

  task automatic model_reset();
    m_valid = 0; m_pc = 0; m_r1 = 0; m_r2 = 0; m_aluop = 0; m_sel = 0;
    m_wd = 0; m_wreg = 0; m_inv = 0; m_stall = 0;
  endtask

  task automatic build(input int kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic [31:0] pc);
    logic [5:0] opc [3];
    opc[0] = 6'h0C; opc[1] = 6'h0D; opc[2] = 6'h0E;
    c_kind = kind; c_rs = rs; c_rt = rt; c_rd = rd; c_imm = imm;
    bus.pc_i = pc;
    if (kind <= 3)       bus.inst_i = {6'h00, rs, rt, rd, 5'h00, 6'h24 + 6'(kind)};
    else if (kind <= 6)  bus.inst_i = {opc[kind-4], rs, rt, imm};
    else if (kind == 7)  bus.inst_i = {6'h0F, rs, rt, imm};
    else if (kind == 8)  bus.inst_i = {6'h23, rs, rt, imm};
    else if (kind == 9)  bus.inst_i = 32'h0;
    else if (kind == 10) bus.inst_i = {6'h3F, rs, rt, imm};
    else                 bus.inst_i = {6'h00, rs, rt, rd, 5'h00, 6'h20};
  endtask

  function automatic logic [31:0] ref_operand(input logic rd, input logic [4:0] a, input logic [31:0] imm);
    if (!rd) return imm;
    if (a == 0) return 32'h0;
    if (bus.ex_wreg_i && bus.ex_wd_i == a) return bus.ex_wdata_i;
    if (bus.mem_wreg_i && bus.mem_wd_i == a) return bus.mem_wdata_i;
    return rf[a];
  endfunction

  function automatic logic ref_hit(input logic rd, input logic [4:0] a);
    return rd && a != 0 && bus.ex_wreg_i && bus.ex_is_load_i && bus.ex_wd_i == a;
  endfunction

  // one clock: check combinational outputs, advance model on the edge, check registers
  task automatic step();
    logic        e_rd1, e_rd2, e_wreg, e_inv, e_haz, e_ready;
    logic [7:0]  e_aluop;
    logic [2:0]  e_sel;
    logic [4:0]  e_wd;
    logic [31:0] e_imm;
    #1;
    e_rd1 = 0; e_rd2 = 0; e_wreg = 0; e_inv = 0; e_aluop = 0; e_sel = 0; e_wd = 0; e_imm = 0;
    if (c_kind <= 3) begin
      e_aluop = 8'h24 + 8'(c_kind); e_sel = 1; e_rd1 = 1; e_rd2 = 1; e_wd = c_rd; e_wreg = 1;
    end else if (c_kind <= 6) begin
      e_aluop = 8'h24 + 8'(c_kind - 4); e_sel = 1; e_rd1 = 1; e_imm = {16'h0, c_imm}; e_wd = c_rt; e_wreg = 1;
    end else if (c_kind == 7) begin
      e_aluop = 8'h25; e_sel = 1; e_rd1 = 1; e_imm = {c_imm, 16'h0}; e_wd = c_rt; e_wreg = 1;
    end else if (c_kind == 8) begin
      e_aluop = 8'hE3; e_sel = 7; e_rd1 = 1; e_wd = c_rt; e_wreg = 1;
      e_imm = c_imm[15] ? {16'hFFFF, c_imm} : {16'h0000, c_imm};
    end else if (c_kind >= 10) begin
      e_inv = 1;
    end
    e_haz   = bus.in_valid && (ref_hit(e_rd1, c_rs) || ref_hit(e_rd2, c_rt));
    e_ready = !e_haz && (!m_valid || bus.out_ready);
    chk("in_ready", 64'(bus.in_ready), 64'(e_ready));
    chk("reg1_read", 64'(bus.reg1_read_o), 64'(e_rd1));
    if (e_rd1) chk("reg1_addr", 64'(bus.reg1_addr_o), 64'(c_rs));
    @(posedge clk);
    if (bus.in_valid && e_ready) begin
      m_valid = 1; m_pc = bus.pc_i; m_aluop = e_aluop; m_sel = e_sel; m_wd = e_wd;
      m_wreg = e_wreg; m_inv = e_inv;
      m_r1 = ref_operand(e_rd1, c_rs, 32'h0);
      m_r2 = ref_operand(e_rd2, c_rt, e_imm);
    end else if (bus.out_ready || !m_valid) begin
      m_valid = 0; m_wreg = 0;
    end
    if (e_haz && m_stall < 65535) m_stall++;
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("wreg", 64'(bus.wreg_o), 64'(m_wreg));
    chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(m_stall));
    if (m_valid) begin
      chk("pc", 64'(bus.pc_o), 64'(m_pc));
      chk("aluop", 64'(bus.aluop_o), 64'(m_aluop));
      chk("alusel", 64'(bus.alusel_o), 64'(m_sel));
      chk("reg1", 64'(bus.reg1_o), 64'(m_r1));
      chk("reg2", 64'(bus.reg2_o), 64'(m_r2));
      chk("wd", 64'(bus.wd_o), 64'(m_wd));
      chk("invalid", 64'(bus.inst_invalid_o), 64'(m_inv));
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    bus.in_valid = 0; bus.out_ready = 1;
    bus.ex_wreg_i = 0; bus.ex_wd_i = 0; bus.ex_wdata_i = 0; bus.ex_is_load_i = 0;
    bus.mem_wreg_i = 0; bus.mem_wd_i = 0; bus.mem_wdata_i = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_pc"}, 64'(bus.pc_o), 64'(0));
    chk({tag, "_aluop"}, 64'(bus.aluop_o), 64'(0));
    chk({tag, "_alusel"}, 64'(bus.alusel_o), 64'(0));
    chk({tag, "_reg1"}, 64'(bus.reg1_o), 64'(0));
    chk({tag, "_reg2"}, 64'(bus.reg2_o), 64'(0));
    chk({tag, "_wd"}, 64'(bus.wd_o), 64'(0));
    chk({tag, "_wreg"}, 64'(bus.wreg_o), 64'(0));
    chk({tag, "_inv"}, 64'(bus.inst_invalid_o), 64'(0));
    chk({tag, "_stall"}, 64'(bus.stall_cnt_o), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    quiet();
    build(9, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst = 1;

    // ori $2,$1,0x1234
    rf[1] = 32'h0F0F_0000;
    build(5, 1, 2, 0, 16'h1234, 32'h100);
    chk("ori_word", 64'(bus.inst_i), 64'(32'h3422_1234));
    bus.in_valid = 1;
    step();
    chk("ori_valid", 64'(bus.out_valid), 64'(1));
    chk("ori_aluop", 64'(bus.aluop_o), 64'(8'h25));
    chk("ori_alusel", 64'(bus.alusel_o), 64'(3'b001));
    chk("ori_reg1", 64'(bus.reg1_o), 64'(32'h0F0F_0000));
    chk("ori_reg2", 64'(bus.reg2_o), 64'(32'h0000_1234));
    chk("ori_wd", 64'(bus.wd_o), 64'(2));
    chk("ori_wreg", 64'(bus.wreg_o), 64'(1));

    // or $3,$1,$2 with EX and MEM both writing $1
    build(1, 1, 2, 3, 0, 32'h104);
    bus.ex_wreg_i = 1; bus.ex_wd_i = 1; bus.ex_wdata_i = 32'hAAAA_AAAA;
    bus.mem_wreg_i = 1; bus.mem_wd_i = 1; bus.mem_wdata_i = 32'h5555_5555;
    step();
    chk("fwd_ex_over_mem", 64'(bus.reg1_o), 64'(32'hAAAA_AAAA));
    bus.mem_wd_i = 2; bus.mem_wdata_i = 32'h1;
    step();
    chk("fwd_mem_rt", 64'(bus.reg2_o), 64'(32'h1));

    // load-use on $4
    build(5, 4, 5, 0, 16'h00FF, 32'h108);
    bus.mem_wreg_i = 0;
    bus.ex_wreg_i = 1; bus.ex_wd_i = 4; bus.ex_is_load_i = 1; bus.ex_wdata_i = 32'h1357_9BDF;
    #1 chk("lu_in_ready", 64'(bus.in_ready), 64'(0));
    step();
    chk("lu_bubble", 64'(bus.out_valid), 64'(0));
    chk("lu_stall1", 64'(bus.stall_cnt_o), 64'(1));
    bus.ex_is_load_i = 0;
    step();
    chk("lu_accept", 64'(bus.out_valid), 64'(1));
    chk("lu_fwd", 64'(bus.reg1_o), 64'(32'h1357_9BDF));

    // EX back-pressure for three cycles, then release
    bus.ex_wreg_i = 0; bus.out_ready = 0;
    build(6, 7, 8, 0, 16'hF0F0, 32'h200);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_held_pc", 64'(bus.pc_o), 64'(32'h108));
    end
    bus.out_ready = 1;
    step();
    chk("bp_new_pc", 64'(bus.pc_o), 64'(32'h200));

    // undecodable word
    build(10, 0, 0, 0, 0, 32'h204);
    chk("inv_word", 64'(bus.inst_i), 64'(32'hFC00_0000));
    step();
    chk("inv_flag", 64'(bus.inst_invalid_o), 64'(1));
    chk("inv_wreg", 64'(bus.wreg_o), 64'(0));

    // $0 source against an EX load writing $0
    build(5, 0, 9, 0, 16'h0001, 32'h208);
    bus.ex_wreg_i = 1; bus.ex_wd_i = 0; bus.ex_is_load_i = 1; bus.ex_wdata_i = 32'hFFFF_FFFF;
    step();
    chk("zero_reg1", 64'(bus.reg1_o), 64'(0));
    chk("zero_nostall", 64'(bus.stall_cnt_o), 64'(1));

    // hold a valid output under back-pressure while a load-use stalls, then reset
    bus.ex_wreg_i = 0; bus.ex_is_load_i = 0;
    build(4, 10, 11, 0, 16'h0F0F, 32'h20C);
    step();
    bus.out_ready = 0;
    bus.ex_wreg_i = 1; bus.ex_wd_i = 6; bus.ex_is_load_i = 1;
    build(5, 6, 12, 0, 16'h0002, 32'h210);
    repeat (4) step();
    chk("pre_rst_valid", 64'(bus.out_valid), 64'(1));
    chk("pre_rst_stall", 64'(bus.stall_cnt_o), 64'(5));
    #2 rst = 0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1;
    quiet();

    // randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      build($urandom_range(0, 11), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
            5'($urandom_range(0, 31)), 16'($urandom), $urandom);
      bus.in_valid     = ($urandom_range(0, 3) != 0);
      bus.out_ready    = ($urandom_range(0, 3) != 0);
      bus.ex_wreg_i    = 1'($urandom_range(0, 1));
      bus.ex_wd_i      = 5'($urandom_range(0, 4));
      bus.ex_wdata_i   = $urandom;
      bus.ex_is_load_i = ($urandom_range(0, 3) == 0);
      bus.mem_wreg_i   = 1'($urandom_range(0, 1));
      bus.mem_wd_i     = 5'($urandom_range(0, 4));
      bus.mem_wdata_i  = $urandom;
      if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
